sram_burst_ctrl: RTL
====================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADR, default 16, SRAM address width.
REQ-002 SHALL have parameter BITS, default 32, data word width.
REQ-003 SHALL have parameter LENW, default 4, burst-length field width; a burst is cmd_len+1 beats, 1..2**LENW.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 SHALL have port cmd_we  input  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have port cmd_adr  input  ADR  burst start address.
REQ-010 SHALL have port cmd_len  input  LENW  beats minus one.
REQ-011 SHALL have port wr_valid  input  1  write beat offered.
REQ-012 SHALL have port wr_ready  output  1  write beat accepted when high together with wr_valid.
REQ-013 SHALL have port wr_data  input  BITS  write beat data.
REQ-014 SHALL have port rd_valid  output  1  rd_data holds a read beat; no backpressure.
REQ-015 SHALL have port rd_last  output  1  marks the final beat of a read burst.
REQ-016 SHALL have port rd_data  output  BITS  read beat data.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-018 SHALL have port mem_adr  output  ADR  drives SRAM adr.
REQ-019 SHALL have port mem_in  output  BITS  drives SRAM in.
REQ-020 SHALL have port mem_we  output  1  drives SRAM WE.
REQ-021 SHALL have port mem_oe  output  1  drives SRAM OE.
REQ-022 SHALL have port mem_out  input  BITS  SRAM registered read data, valid the cycle after OE.

Function
REQ-023 SHALL implement FSM states IDLE, WRITE and READ.
REQ-024 cmd_ready SHALL be high only in IDLE.
REQ-025 On cmd_valid&&cmd_ready, the block SHALL capture the start address into cur_adr and cmd_len into beat counter cnt, and go to WRITE if cmd_we else READ.
REQ-026 In WRITE, wr_ready SHALL be 1 and mem_we SHALL equal wr_valid, with mem_adr=cur_adr and mem_in=wr_data combinationally (same cycle).
REQ-027 Each accepted write beat SHALL increment cur_adr and decrement cnt; a beat accepted with cnt==0 SHALL return the FSM to IDLE on that edge.
REQ-028 In WRITE with wr_valid=0 (idle beat), no write SHALL occur and the state SHALL hold.
REQ-029 In READ, mem_oe SHALL be 1 every cycle with mem_adr=cur_adr; cur_adr SHALL increment and cnt decrement per cycle; the FSM SHALL leave for IDLE after the cnt==0 cycle (exactly cmd_len+1 OE cycles).
REQ-030 rd_valid SHALL be registered: high the cycle after each mem_oe cycle; rd_data SHALL equal mem_out; rd_last SHALL be high with the beat issued at cnt==0.
REQ-031 cur_adr SHALL wrap modulo 2**ADR (all-ones +1 -> 0) without error.
REQ-032 mem_we and mem_oe SHALL never both be high; outside WRITE mem_we=0; outside READ mem_oe=0.
REQ-033 wr_valid outside WRITE SHALL be ignored (wr_ready=0, no write); cmd_valid while busy SHALL be ignored.
REQ-034 Commands SHALL be separated by at least one IDLE cycle; the trailing rd_valid of a read burst MAY coincide with the next command acceptance.
REQ-035 Throughput SHALL be one beat per cycle within a burst.

Reset
REQ-036 While rst_n=0: state=IDLE, cur_adr=0, cnt=0, rd_valid=0, rd_last=0, busy=0, cmd_ready=1, wr_ready=0, mem_we=0, mem_oe=0.
REQ-037 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously); the aborted burst SHALL NOT resume after release.
REQ-038 rd_data SHALL NOT be reset (passes through mem_out).

Verification
REQ-039 Write cmd adr=0x0010 len=3, wr_data 0xA0..0xA3 back-to-back -> mem_we high 4 cycles at adr 0x10..0x13, then IDLE, cmd_ready=1.
REQ-040 Read cmd adr=0x0010 len=3 -> mem_oe 4 cycles; rd_valid 4 cycles starting one cycle after first OE, data 0xA0..0xA3, rd_last on 0xA3.
REQ-041 Write adr=0xFFFE len=3 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; read-back matches.
REQ-042 Write burst len=1 with wr_valid low for 2 cycles between beats -> exactly 2 writes, busy high throughout, no extra mem_we.
REQ-043 rst_n pulsed low during beat 2 of a len=7 read -> mem_oe drops in the same cycle, rd_valid=0 next cycle, FSM IDLE, no further beats.
REQ-044 cmd_valid and wr_valid held high while IDLE/READ -> no SRAM write, only the first command accepted.

Source files
------------

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port synchronous SRAM: accepts write/read burst
// commands and streams one beat per cycle, with registered read-data valid/last.
module sram_burst_ctrl #(
  parameter int ADR  = 16,
  parameter int BITS = 32,
  parameter int LENW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [ADR-1:0]  cmd_adr,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [BITS-1:0] wr_data,
  output logic            rd_valid,
  output logic            rd_last,
  output logic [BITS-1:0] rd_data,
  output logic            busy,
  output logic [ADR-1:0]  mem_adr,
  output logic [BITS-1:0] mem_in,
  output logic            mem_we,
  output logic            mem_oe,
  input  logic [BITS-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ADR-1:0]  cur_adr_q, cur_adr_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic            last_beat;

  // Address arithmetic deliberately wraps modulo 2**ADR.
  function automatic logic [ADR-1:0] adr_next(input logic [ADR-1:0] a);
    return a + ADR'(1);
  endfunction

  function automatic logic [LENW-1:0] cnt_next(input logic [LENW-1:0] c);
    return c - LENW'(1);
  endfunction

  assign last_beat = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cur_adr_d  = cur_adr_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_adr_d = cmd_adr;
          cnt_d     = cmd_len;
          state_d   = cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        // Idle write beats (wr_valid low) simply hold address, count and state.
        if (wr_valid) begin
          cur_adr_d = adr_next(cur_adr_q);
          cnt_d     = cnt_next(cnt_q);
          if (last_beat) state_d = IDLE;
        end
      end
      READ: begin
        // The SRAM returns data one cycle after OE, so valid/last are delayed by a flop.
        rd_valid_d = 1'b1;
        rd_last_d  = last_beat;
        cur_adr_d  = adr_next(cur_adr_q);
        cnt_d      = cnt_next(cnt_q);
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_adr_q  <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_adr_q  <= cur_adr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign mem_we    = (state_q == WRITE) && wr_valid;
  assign mem_oe    = (state_q == READ);
  assign mem_adr   = cur_adr_q;
  assign mem_in    = wr_data;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = mem_out;

endmodule
